// File: rtl/store_write_scheduler.sv
// ---------------------------------------------------------------------------
// store_write_scheduler
//
// Store buffer sitting between the four issue lanes and the single write
// port of the data memory. Up to four stores per cycle are accepted
// all-or-nothing, packed in program order (lane 0 oldest) into a circular
// buffer. One entry per cycle drains into the memory write port. Loads probe
// the buffer combinationally and receive the youngest matching store.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   st_valid[3:0]   bit i set when lane i presents a store
//   st_addrN        store byte address for lane N (bits [1:0] ignored)
//   st_dataN        store data for lane N
//   st_ready        every presented store is accepted at this edge
//   mem_write       memory write enable (buffer not empty)
//   mem_write_addr  head entry word address as a byte address, 0 when idle
//   mem_write_data  head entry data, 0 when idle
//   ld_addr         load address from the memory stage
//   ld_hit          some buffered store matches ld_addr
//   ld_data         data of the youngest matching store, 0 on no hit
//   count           occupied entries (registered)
//   empty           count == 0
// ---------------------------------------------------------------------------
module store_write_scheduler #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    st_valid,
    input  logic [31:0]   st_addr0,
    input  logic [31:0]   st_addr1,
    input  logic [31:0]   st_addr2,
    input  logic [31:0]   st_addr3,
    input  logic [31:0]   st_data0,
    input  logic [31:0]   st_data1,
    input  logic [31:0]   st_data2,
    input  logic [31:0]   st_data3,
    output logic          st_ready,
    output logic          mem_write,
    output logic [31:0]   mem_write_addr,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic [31:0]   ld_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [29:0]   laneAddr [4];
    logic [31:0]   laneData [4];
    logic [2:0]    laneOffset [4];
    logic [2:0]    validCount;
    logic [CW-1:0] freeSlots;
    logic          accept;
    logic [PW-1:0] fwdIdx;
    logic          unusedAddrBits;

    // Byte-offset bits of every address are don't-care for word stores.
    assign unusedAddrBits = ^{st_addr0[1:0], st_addr1[1:0], st_addr2[1:0],
                              st_addr3[1:0], ld_addr[1:0]};

    // Gather the lanes into arrays so the packing logic can loop over them.
    always_comb begin
        laneAddr[0] = st_addr0[31:2];
        laneAddr[1] = st_addr1[31:2];
        laneAddr[2] = st_addr2[31:2];
        laneAddr[3] = st_addr3[31:2];
        laneData[0] = st_data0;
        laneData[1] = st_data1;
        laneData[2] = st_data2;
        laneData[3] = st_data3;
    end

    // Each valid lane lands at tail plus the number of valid lanes below it,
    // so invalid lanes leave no holes in the buffer.
    always_comb begin
        validCount = '0;
        for (int k = 0; k < 4; k++) begin
            laneOffset[k] = validCount;
            validCount    = validCount + {2'b00, st_valid[k]};
        end
    end

    // Acceptance ignores the entry draining this same cycle, which keeps the
    // ready path free of the drain decision. An empty request is always ready.
    always_comb begin
        freeSlots = CW'(DEPTH) - count_q;
        st_ready  = rst_n && (freeSlots >= CW'(validCount));
        accept    = st_ready;
    end

    // The head entry is always on the write port whenever anything is held;
    // the data outputs are zeroed when idle so the port is clean.
    always_comb begin
        mem_write      = (count_q != '0);
        mem_write_addr = '0;
        mem_write_data = '0;
        if (mem_write) begin
            mem_write_addr = {addr_q[head_q], 2'b00};
            mem_write_data = data_q[head_q];
        end
        count = count_q;
        empty = (count_q == '0);
    end

    // Pointer and occupancy next state. Pointers wrap naturally modulo DEPTH
    // because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q + (mem_write ? PW'(1) : '0);
        tail_d  = tail_q + (accept ? PW'(validCount) : '0);
        count_d = count_q + (accept ? CW'(validCount) : '0)
                          - (mem_write ? CW'(1) : '0);
    end

    // Reset simply abandons whatever is buffered; stale storage contents are
    // harmless because every reader is gated by count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage. Acceptance guarantees every target slot is free, so a
    // write never collides with the entry being drained.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (accept && st_valid[k]) begin
                addr_q[tail_q + PW'(laneOffset[k])] <= laneAddr[k];
                data_q[tail_q + PW'(laneOffset[k])] <= laneData[k];
            end
        end
    end

    // Forwarding walks the occupied entries oldest to youngest so that a
    // later match overrides an earlier one, leaving the youngest store's data.
    // The draining head is included since memory has not yet absorbed it.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwdIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwdIdx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwdIdx];
            end
        end
    end

endmodule

// File: doc/store_write_scheduler.md
Name: store_write_scheduler

Overview:
- Store buffer and write-port scheduler between the four issue lanes and the single-write-port data memory.
- Accepts up to four stores per cycle, queues them in program order (lane 0 oldest), and drains one per cycle into the memory write port.
- Forwards the youngest matching buffered store to the load path so loads see pending stores.

Parameters:
DEPTH, 8, number of buffer entries; power of two, at least 4.
CW, 4, count width; must equal $clog2(DEPTH+1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
st_valid  input  4  bit i = lane i presents a store this cycle.
st_addr0..st_addr3  input  32 each  store byte address per lane; word-aligned, bits [1:0] ignored.
st_data0..st_data3  input  32 each  store data per lane.
st_ready  output  1  all presented stores are accepted at this edge.
mem_write  output  1  write enable to the data memory.
mem_write_addr  output  32  head entry address.
mem_write_data  output  32  head entry data.
ld_addr  input  32  load word address from the memory stage.
ld_hit  output  1  a buffered store matches ld_addr.
ld_data  output  32  data of the youngest matching store.
count  output  CW  occupied entries (registered).
empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries {addr[31:2], data}, head/tail pointers wrapping modulo DEPTH, registered count.
- st_ready (combinational) = rst_n && (DEPTH - count) >= popcount(st_valid).
  - Conservative: the same-cycle drain is not credited.
  - st_valid == 0 gives st_ready = 1 even when full.
- Accept is all-or-nothing.
  - When st_ready=1, every valid lane is written at the edge, packed contiguously from tail in ascending lane order, skipping invalid lanes. Tail advances by popcount.
  - When st_ready=0, nothing is written; upstream holds all lanes unchanged.
- Drain: mem_write = (count != 0).
  - mem_write_addr = {head.addr, 2'b00}; mem_write_data = head.data.
  - Both data outputs are forced to 0 when mem_write=0.
  - The memory captures the write at the edge; head advances by 1 at the same edge.
- Latency: a store accepted at edge N is presented from cycle N+1 and written to memory at edge N+1 at the earliest. Lane k of a group is written k positions after the group's first store.
- count_next = count + accepted - (mem_write ? 1 : 0).
  - Simultaneous accept and drain is legal at every occupancy.
  - count never exceeds DEPTH and never underflows.
- Forwarding (combinational):
  - Compare ld_addr[31:2] against every occupied entry, including the head being drained this cycle.
  - ld_hit=1 if any entry matches; ld_data comes from the match nearest tail, i.e. the youngest.
  - No match: ld_hit=0, ld_data=0.
  - Stores presented in the same cycle are not forwarded. The issue logic never places a load after a same-group store to the same word.
- Memory bypass overlap: the memory's internal same-cycle write bypass and ld_hit may both cover the head entry. They carry identical data, so either source is correct.
- Reset: rst_n low at a rising edge clears head, tail and count regardless of in-flight stores. Pending entries are discarded and not written.
- Output values while rst_n is low or just after the reset edge:
  - st_ready=0 while rst_n is low.
  - After the reset edge: mem_write=0, mem_write_addr=0, mem_write_data=0, ld_hit=0, ld_data=0, count=0, empty=1.
- Reset mid-drain: the write presented in the reset cycle still occurs, because mem_write derives from pre-reset state. Nothing further is written after the reset edge.

Test Plan:
- Single store: lane 2 stores 0x0000_0100/0xDEAD_BEEF at edge 1 -> cycle 1 mem_write=1, addr 0x100, data 0xDEADBEEF; count returns to 0 after edge 2; empty=1.
- Four-lane burst ordering: lanes 0-3 store addresses 0x10, 0x14, 0x18, 0x1C in one cycle -> memory writes in that order on four consecutive edges; count sequence 4, 3, 2, 1, 0.
- Full/backpressure, DEPTH=8:
  - Two 4-lane bursts with memory writing -> after the second accept count=7 (4+4-1).
  - A third 2-lane request -> st_ready=0 while count>6; accepted once count ≤ 6; no entry lost or duplicated.
  - st_valid=0 at full -> st_ready=1.
- Forwarding youngest: lanes 0 and 3 both store address 0x40 with data 1 and 4 -> next cycle ld_addr=0x40 gives ld_hit=1, ld_data=4; ld_addr=0x44 gives ld_hit=0, ld_data=0.
- Wrap-around: 20 single stores over 30 cycles with ld_addr tracking each -> pointers wrap past 7 and all 20 memory writes appear in order with correct data.
- Reset mid-operation:
  - count=5, rst_n=0 for one edge -> count=0, mem_write=0, ld_hit=0; the 4 remaining entries are never written.
  - A new store after reset drains normally.
